// File: rtl/dm_load_wb.sv
// MEM/WB stage register and load-return path: aligns/extends the block-RAM or
// bridge read word one cycle after the address, flags bad loads, and holds load data across WB stalls.
module dm_load_wb #(
  parameter logic [31:0] DM_LIMIT     = 32'h0000_2000,
  parameter logic [31:0] PERIPH_BASE  = 32'h0000_7F00,
  parameter logic [31:0] PERIPH_LIMIT = 32'h0000_7F20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        m_valid,
  input  logic [2:0]  m_load_type,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_result,
  input  logic [31:0] m_pc,
  input  logic [4:0]  m_rd,
  input  logic        m_regwrite,
  input  logic [31:0] dm_rdata,
  input  logic [31:0] bridge_rdata,
  output logic        w_valid,
  output logic [31:0] w_pc,
  output logic [4:0]  w_rd,
  output logic        w_regwrite,
  output logic [31:0] w_wdata,
  output logic        w_adel
);

  localparam logic [2:0] LT_NONE = 3'd0, LT_LW = 3'd1, LT_LH = 3'd2,
                         LT_LHU = 3'd3, LT_LB = 3'd4, LT_LBU = 3'd5;

  typedef enum logic {LIVE, HELD} state_t;

  typedef struct packed {
    logic [2:0]  lt;
    logic [1:0]  off;
    logic        periph;
    logic        rw;
    logic [31:0] result;
  } wb_t;

  wb_t         wb;
  state_t      state;
  logic [31:0] hold_reg;

  // MEM-side decode: codes 6/7 collapse to "no load" so they never raise adel.
  logic [2:0] m_lt;
  logic       m_in_dm, m_in_per, m_adel;

  always_comb begin
    m_lt     = (m_valid && m_load_type >= LT_LW && m_load_type <= LT_LBU) ? m_load_type : LT_NONE;
    m_in_dm  = m_addr < DM_LIMIT;
    m_in_per = (m_addr >= PERIPH_BASE) && (m_addr < PERIPH_LIMIT);
    m_adel   = 1'b0;
    if (m_lt != LT_NONE)
      m_adel = ((m_lt == LT_LW) && (m_addr[1:0] != 2'b00)) ||
               (((m_lt == LT_LH) || (m_lt == LT_LHU)) && m_addr[0]) ||
               (!m_in_dm && !m_in_per) ||
               (m_in_per && (m_lt != LT_LW));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_valid <= 1'b0;
      w_pc    <= '0;
      w_rd    <= '0;
      w_adel  <= 1'b0;
      wb      <= '0;
    end else if (flush || (!stall && !m_valid)) begin
      w_valid <= 1'b0;
      w_pc    <= '0;
      w_rd    <= '0;
      w_adel  <= 1'b0;
      wb      <= '0;
    end else if (!stall) begin
      w_valid   <= 1'b1;
      w_pc      <= m_pc;
      w_rd      <= m_rd;
      w_adel    <= m_adel;
      wb.lt     <= m_lt;
      wb.off    <= m_addr[1:0];
      wb.periph <= m_in_per;
      wb.rw     <= m_regwrite;
      wb.result <= m_result;
    end
  end

  // Return-path alignment from the registered byte offset.
  logic [31:0] src, shifted, ext;
  logic [15:0] half;

  always_comb begin
    src     = wb.periph ? bridge_rdata : dm_rdata;
    shifted = src >> {wb.off, 3'b000};
    half    = wb.off[1] ? src[31:16] : src[15:0];
    case (wb.lt)
      LT_LW:   ext = src;
      LT_LH:   ext = {{16{half[15]}}, half};
      LT_LHU:  ext = {16'h0000, half};
      LT_LB:   ext = {{24{shifted[7]}}, shifted[7:0]};
      LT_LBU:  ext = {24'h000000, shifted[7:0]};
      default: ext = wb.result;
    endcase
  end

  // The RAM may change its output while WB is stalled, so snapshot the load value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= LIVE;
      hold_reg <= '0;
    end else begin
      case (state)
        LIVE:
          if (stall && !flush && w_valid && !w_adel && (wb.lt != LT_NONE)) begin
            hold_reg <= ext;
            state    <= HELD;
          end
        HELD:
          if (!stall || flush) state <= LIVE;
        default: state <= LIVE;
      endcase
    end
  end

  always_comb begin
    w_regwrite = w_valid & wb.rw & ~w_adel & (w_rd != 5'd0);
    if (w_adel)
      w_wdata = '0;
    else if (wb.lt != LT_NONE && state == HELD)
      w_wdata = hold_reg;
    else
      w_wdata = ext;
  end

endmodule

// File: doc/dm_load_wb.md
Name: dm_load_wb

Overview:
- MEM/WB stage register and load-return path, directly downstream of the data memory in the pipelined MIPS core.
- The data memory's block RAM returns read data one cycle after the address is presented. This block registers the MEM-stage load attributes and aligns/extends the returned word using the registered byte offset.
- It selects between DM and bridge (peripheral) read data, flags misaligned or out-of-range loads, and preserves load data across WB stalls.

Parameters:
- DM_LIMIT, 32'h00002000, first address above data memory; DM is [0, DM_LIMIT).
- PERIPH_BASE, 32'h00007F00, first peripheral address.
- PERIPH_LIMIT, 32'h00007F20, first address above peripheral window.

Ports:
- clk  input  1  single clock.
- reset  input  1  asynchronous, active-low reset.
- stall  input  1  hold WB register contents this cycle.
- flush  input  1  replace WB contents with a bubble.
- m_valid  input  1  MEM stage holds a real instruction.
- m_load_type  input  3  0 none, 1 lw, 2 lh, 3 lhu, 4 lb, 5 lbu; 6/7 treated as none.
- m_addr  input  32  effective address (ALU result).
- m_result  input  32  writeback value for non-load instructions.
- m_pc  input  32  instruction PC.
- m_rd  input  5  destination register.
- m_regwrite  input  1  instruction writes rd.
- dm_rdata  input  32  DM read word, valid the cycle after m_addr.
- bridge_rdata  input  32  peripheral read word, same timing as dm_rdata.
- w_valid  output  1  WB stage holds a real instruction.
- w_pc  output  32  registered m_pc.
- w_rd  output  5  registered m_rd.
- w_regwrite  output  1  final register-file write enable.
- w_wdata  output  32  register-file write data.
- w_adel  output  1  address-error-on-load flag for the exception unit.

Behaviour:
- Reset (reset=0, async): w_valid=0, w_pc=0, w_rd=0, w_regwrite=0, w_wdata=0, w_adel=0, held state cleared, FSM=LIVE.
- Register update at posedge clk, by priority:
  - flush=1 → bubble: valid/regwrite/adel/load_type cleared; pc, rd, result zeroed. Flush wins over stall.
  - else stall=1 → all registers hold.
  - else capture m_*. If m_valid=0, capture as a bubble.
- Load error detection, evaluated on m_* at capture and registered into w_adel:
  - lw with addr[1:0]!=0.
  - lh/lhu with addr[0]!=0.
  - Address in neither [0,DM_LIMIT) nor [PERIPH_BASE,PERIPH_LIMIT).
  - Any non-lw load to the peripheral window.
  - Non-loads never raise adel. A bubble never raises adel.
- w_regwrite = w_valid & reg_regwrite & ~w_adel & (w_rd!=0).
- Source select: registered is_periph=1 → bridge_rdata, else dm_rdata.
- Extension, using the registered offset off=addr[1:0] (little-endian byte lanes; lane k = bits 8k+7:8k):
  - lw: word.
  - lh: sign-extend half off[1]. lhu: zero-extend half off[1].
  - lb: sign-extend byte off. lbu: zero-extend byte off.
  - Non-load: w_wdata = registered m_result.
- Stall hold FSM, because RAM output is not guaranteed stable while stalled:
  - LIVE: w_wdata is the combinational extension of the current source.
    - On a posedge with stall=1, flush=0, and a valid non-adel load in WB: latch the extended value into hold_reg → HELD.
  - HELD: w_wdata = hold_reg.
    - Any posedge with stall=0 or flush=1 → LIVE.
- Non-load in WB while stalled: data comes from the registered m_result, so no HELD entry.
- w_adel=1: w_wdata is don't-care and is driven to 0.
- Latency: one cycle from MEM to WB. No back-pressure outputs.

Test Plan:
- Reset mid-load:
  - Stimulus: valid lw captured, then reset=0 asynchronously between edges.
  - Required: all outputs 0 immediately; FSM LIVE after release.
- Byte/half extension:
  - Stimulus: dm_rdata=32'h80F17F82.
  - Required: lb off=0 → FFFFFF82; lbu off=3 → 00000080; lh off=2 → FFFF80F1; lhu off=0 → 00007F82; lw off=0 → 80F17F82.
- Misalignment and range:
  - Stimulus: lw addr=0x0000_0006; lh addr=0x0000_0001; lw addr=0x0000_3000; lb addr=0x0000_7F04.
  - Required: each gives w_adel=1, w_regwrite=0.
  - Stimulus: lw addr=0x0000_7F04 with bridge_rdata=0x12345678.
  - Required: w_wdata=0x12345678, w_adel=0.
- Stall hold:
  - Stimulus: lbu off=1 with dm_rdata=0x0000AB00; stall=1 for 3 cycles while dm_rdata changes to 0xFFFFFFFF.
  - Required: w_wdata stays 0x000000AB throughout; stall=0 returns the FSM to LIVE.
- Flush vs stall:
  - Stimulus: stall=1 and flush=1 on the same edge.
  - Required: w_valid=0, w_regwrite=0 next cycle, FSM LIVE.
- $0 destination:
  - Stimulus: load with rd=0, valid aligned address.
  - Required: w_regwrite=0, w_adel=0.
